// File: rtl/imem_loader.sv
// imem_loader
//   Programs 32-bit instruction words, received over a valid/ready stream,
//   into a byte-wide instruction memory. Each word is written big-endian
//   (MSB at the lowest address) across 4 consecutive byte addresses, so the
//   fetch side can rebuild it as {mem[pc], mem[pc+1], mem[pc+2], mem[pc+3]}.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active low (0 = reset)
//   start       begin a load session (only honoured while idle)
//   base_addr   first byte address of the session, bits [1:0] ignored
//   in_valid    in_word / in_last are valid
//   in_ready    loader accepts a word this cycle
//   in_word     instruction word
//   in_last     this word ends the session
//   mem_we      byte write strobe
//   mem_addr    byte write address (0 when mem_we = 0)
//   mem_wdata   byte write data (0 when mem_we = 0)
//   busy        session in progress
//   done        one-cycle pulse at the end of a session
//   overflow    sticky: a word was dropped because it would run past DEPTH
//   word_count  words fully written in the current session
//
// All outputs are registered. Each accepted word costs one accept cycle plus
// four write cycles.

module imem_loader #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_word,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-2:0] word_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // The pointer carries one extra bit so that stepping past the top of the
    // memory lands on DEPTH instead of wrapping back to address 0.
    localparam logic [ADDR_W:0]   LAST_PTR   = (ADDR_W+1)'(DEPTH - 4);
    localparam logic [ADDR_W:0]   PTR_STEP   = {{(ADDR_W-2){1'b0}}, 3'b100};
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-2:0] CNT_ONE    = {{(ADDR_W-2){1'b0}}, 1'b1};

    state_t            state_r;
    logic [ADDR_W:0]   ptr_r;
    logic [1:0]        byte_idx_r;
    logic [31:0]       word_r;
    logic              last_r;

    logic [1:0]        nxt_idx_s;
    logic [ADDR_W-1:0] nxt_addr_s;

    // Big-endian byte lane select: lane 0 is the most significant byte.
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    byte_sel = w[31:24];
            2'd1:    byte_sel = w[23:16];
            2'd2:    byte_sel = w[15:8];
            2'd3:    byte_sel = w[7:0];
            default: byte_sel = 8'd0;
        endcase
    endfunction

    // Lane index and byte address of the next write beat within the word.
    always_comb begin
        nxt_idx_s  = byte_idx_r + 2'd1;
        nxt_addr_s = ptr_r[ADDR_W-1:0] + {{(ADDR_W-2){1'b0}}, nxt_idx_s};
    end

    // Session FSM; outputs are registered and set for the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            ptr_r      <= '0;
            byte_idx_r <= 2'd0;
            word_r     <= 32'd0;
            last_r     <= 1'b0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done      <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= 8'd0;
                    // in_valid is deliberately not looked at here.
                    if (start) begin
                        ptr_r      <= {1'b0, base_addr & ALIGN_MASK};
                        word_count <= '0;
                        overflow   <= 1'b0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        state_r    <= ACCEPT;
                    end else begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                ACCEPT: begin
                    if (in_valid) begin
                        word_r   <= in_word;
                        last_r   <= in_last;
                        in_ready <= 1'b0;
                        if (ptr_r > LAST_PTR) begin
                            // No room for a whole word: drop it and close the session.
                            overflow <= 1'b1;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state_r  <= DONE;
                        end else begin
                            byte_idx_r <= 2'd0;
                            mem_we     <= 1'b1;
                            mem_addr   <= ptr_r[ADDR_W-1:0];
                            mem_wdata  <= byte_sel(in_word, 2'd0);
                            state_r    <= WRITE;
                        end
                    end else begin
                        state_r <= ACCEPT;
                    end
                end
                WRITE: begin
                    if (byte_idx_r == 2'd3) begin
                        ptr_r      <= ptr_r + PTR_STEP;
                        word_count <= word_count + CNT_ONE;
                        mem_we     <= 1'b0;
                        mem_addr   <= '0;
                        mem_wdata  <= 8'd0;
                        if (last_r) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            in_ready <= 1'b1;
                            state_r  <= ACCEPT;
                        end
                    end else begin
                        byte_idx_r <= nxt_idx_s;
                        mem_addr   <= nxt_addr_s;
                        mem_wdata  <= byte_sel(word_r, nxt_idx_s);
                        state_r    <= WRITE;
                    end
                end
                DONE: begin
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    in_ready <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    in_ready  <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= 8'd0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [8:0]  base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        in_last;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [7:0]  word_count;

    imem_loader #(.DEPTH(512), .ADDR_W(9)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .overflow(overflow), .word_count(word_count)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int done_cnt;
    int overlap_cnt;
    logic        ok;
    logic [8:0]  wa_q[$];
    logic [7:0]  wd_q[$];
    int          hs_q[$];
    logic [31:0] exp_w[4];

    // Cycle counter used to time handshakes.
    always @(posedge clk) cyc <= cyc + 1;

    // Mid-cycle monitor: logs writes, handshakes, done pulses and write/ready overlap.
    always @(negedge clk) begin
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end
        if (in_valid && in_ready) hs_q.push_back(cyc);
        if (done) done_cnt++;
        if (mem_we && in_ready) overlap_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        hs_q.delete();
        done_cnt    = 0;
        overlap_cnt = 0;
    endtask

    task automatic do_start(input logic [8:0] b);
        start     = 1'b1;
        base_addr = b;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic l, input int gap);
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_word  = w;
        in_last  = l;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            tick();
        end
        if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (done) ok = 1'b1;
            else tick();
        end
        if (!ok) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
        tick();
    endtask

    // Expected byte stream: word k, lane j lands at base+4k+j, MSB first.
    task automatic check_stream(input string tag, input logic [8:0] base, input int nw);
        logic [31:0] w;
        int idx;
        chk({tag, "_nwrites"}, wa_q.size(), 4 * nw);
        for (int k = 0; k < nw; k++) begin
            w = exp_w[k];
            for (int j = 0; j < 4; j++) begin
                idx = 4 * k + j;
                if (idx < wa_q.size()) begin
                    chk($sformatf("%s_addr%0d", tag, idx), {23'd0, wa_q[idx]}, {23'd0, base} + idx);
                    chk($sformatf("%s_data%0d", tag, idx), {24'd0, wd_q[idx]}, {24'd0, w[31-8*j -: 8]});
                end
            end
        end
    endtask

    // Directed test sequence.
    initial begin
        rst = 1'b0; start = 1'b0; base_addr = 9'd0;
        in_valid = 1'b0; in_word = 32'd0; in_last = 1'b0;
        done_cnt = 0; overlap_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_busy_done_ovf", {29'd0, busy, done, overflow}, 32'd0);
        chk("rst_addr_data_cnt", {7'd0, mem_addr, mem_wdata, word_count}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // 1: single word at base 0.
        clear_log();
        do_start(9'h000);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        send_word(32'h24010000, 1'b1, 0);
        wait_done("t1");
        chk("t1_a0", {23'd0, wa_q[0]}, 32'd0);
        chk("t1_d0", {24'd0, wd_q[0]}, 32'h24);
        chk("t1_d1", {24'd0, wd_q[1]}, 32'h01);
        chk("t1_d3", {24'd0, wd_q[3]}, 32'h00);
        chk("t1_a3", {23'd0, wa_q[3]}, 32'd3);
        chk("t1_nwr", wa_q.size(), 32'd4);
        chk("t1_done_cycles", done_cnt, 32'd1);
        chk("t1_wcount", {24'd0, word_count}, 32'd1);
        chk("t1_overflow", {31'd0, overflow}, 32'd0);
        chk("t1_busy_end", {31'd0, busy}, 32'd0);

        // 2: three back-to-back words at base 8, in_valid continuously high.
        exp_w[0] = 32'h11223344; exp_w[1] = 32'h55667788; exp_w[2] = 32'h99AABBCC;
        clear_log();
        do_start(9'h008);
        send_word(exp_w[0], 1'b0, 0);
        send_word(exp_w[1], 1'b0, 0);
        send_word(exp_w[2], 1'b1, 0);
        wait_done("t2");
        check_stream("t2", 9'h008, 3);
        chk("t2_nhs", hs_q.size(), 32'd3);
        if (hs_q.size() == 3) begin
            chk("t2_hs_gap1", hs_q[1] - hs_q[0], 32'd5);
            chk("t2_hs_gap2", hs_q[2] - hs_q[1], 32'd5);
        end
        chk("t2_wcount", {24'd0, word_count}, 32'd3);
        chk("t2_done_cycles", done_cnt, 32'd1);
        chk("t2_overlap", overlap_cnt, 32'd0);

        // 3: last legal word then overflow.
        exp_w[0] = 32'hDEADBEEF;
        clear_log();
        do_start(9'h1FD);
        send_word(exp_w[0], 1'b0, 0);
        send_word(32'h01020304, 1'b1, 0);
        wait_done("t3");
        check_stream("t3", 9'h1FC, 1);
        chk("t3_nhs", hs_q.size(), 32'd2);
        chk("t3_overflow", {31'd0, overflow}, 32'd1);
        chk("t3_wcount", {24'd0, word_count}, 32'd1);
        chk("t3_done_cycles", done_cnt, 32'd1);
        repeat (2) tick();
        chk("t3_overflow_hold", {31'd0, overflow}, 32'd1);

        // 4: asynchronous reset in the middle of a word.
        clear_log();
        do_start(9'h040);
        send_word(32'hA1B2C3D4, 1'b1, 0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (mem_we && mem_addr == 9'h042) ok = 1'b1;
            else tick();
        end
        chk("t4_reach_byte2", {31'd0, ok}, 32'd1);
        chk("t4_byte2_data", {24'd0, mem_wdata}, 32'hC3);
        rst = 1'b0;
        #1;
        chk("t4_rst_outputs", {28'd0, mem_we, busy, in_ready, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("t4_after_rst", {29'd0, busy, in_ready, mem_we}, 32'd0);
        clear_log();
        in_valid = 1'b1; in_word = 32'hFFFFFFFF; in_last = 1'b1;
        repeat (6) tick();
        in_valid = 1'b0;
        chk("t4_idle_nhs", hs_q.size(), 32'd0);
        chk("t4_idle_nwr", wa_q.size(), 32'd0);

        // 5: in_valid high before/with start; start pulsed during WRITE is ignored.
        exp_w[0] = 32'h0A0B0C0D; exp_w[1] = 32'h0E0F1011;
        clear_log();
        in_valid = 1'b1; in_word = 32'hFFFFFFFF; in_last = 1'b0;
        repeat (3) tick();
        chk("t5_idle_nhs", hs_q.size(), 32'd0);
        in_word = exp_w[0];
        do_start(9'h020);
        chk("t5_no_hs_on_start", hs_q.size(), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("t5_in_write", {31'd0, mem_we}, 32'd1);
        do_start(9'h100);
        send_word(exp_w[1], 1'b1, 0);
        wait_done("t5");
        check_stream("t5", 9'h020, 2);
        chk("t5_nhs", hs_q.size(), 32'd2);
        chk("t5_wcount", {24'd0, word_count}, 32'd2);
        chk("t5_done_cycles", done_cnt, 32'd1);

        // 6: same stream as test 2 with gaps of 0, 3 and 7 idle cycles.
        exp_w[0] = 32'h11223344; exp_w[1] = 32'h55667788; exp_w[2] = 32'h99AABBCC;
        clear_log();
        do_start(9'h008);
        send_word(exp_w[0], 1'b0, 0);
        send_word(exp_w[1], 1'b0, 3);
        send_word(exp_w[2], 1'b1, 7);
        wait_done("t6");
        check_stream("t6", 9'h008, 3);
        chk("t6_wcount", {24'd0, word_count}, 32'd3);
        chk("t6_overlap", overlap_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
